// File: rtl/tia_bus_arbiter.sv
// Two-master Wishbone arbiter for the TIA register port: one single-cycle strobe per access.
// Define TIA_ARB_TIMEOUT_EN to add a WAIT timeout that answers with an error response.
module tia_bus_arbiter #(
    parameter int unsigned WB_ADDR_WIDTH  = 7,
    parameter int unsigned WB_DATA_WIDTH  = 8,
    parameter int unsigned STARVE_LIMIT   = 15,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     m0_stb_i,
    input  logic                     m0_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] m0_dat_i,
    output logic                     m0_ack_o,
    output logic                     m0_err_o,
    output logic [WB_DATA_WIDTH-1:0] m0_dat_o,
    input  logic                     m1_stb_i,
    input  logic                     m1_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] m1_dat_i,
    output logic                     m1_ack_o,
    output logic                     m1_err_o,
    output logic [WB_DATA_WIDTH-1:0] m1_dat_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [WB_ADDR_WIDTH-1:0] s_adr_o,
    output logic [WB_DATA_WIDTH-1:0] s_dat_o,
    input  logic                     s_ack_i,
    input  logic [WB_DATA_WIDTH-1:0] s_dat_i,
    input  logic                     stall_cpu_i,
    output logic [1:0]               grant_o
);
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    if (STARVE_LIMIT == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("tia_bus_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be non-zero");
    end

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e                   state_q;
    logic [StarveW-1:0]       starve_q;
    logic [1:0]               grant_q;
    logic                     s_stb_q;
    logic                     s_we_q;
    logic [WB_ADDR_WIDTH-1:0] s_adr_q;
    logic [WB_DATA_WIDTH-1:0] s_dat_q;
    logic                     m0_ack_q;
    logic                     m1_ack_q;
    logic [WB_DATA_WIDTH-1:0] m0_dat_q;
    logic [WB_DATA_WIDTH-1:0] m1_dat_q;
    logic                     m1_wins;

    // Master 1 takes the slot when alone, when the CPU is parked in WSYNC, or when starved.
    assign m1_wins = m1_stb_i & (~m0_stb_i | stall_cpu_i | (starve_q == StarveMax));

`ifdef TIA_ARB_TIMEOUT_EN
    localparam int unsigned TimeoutW = ($clog2(TIMEOUT_CYCLES) > 4) ? $clog2(TIMEOUT_CYCLES) : 4;
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);

    logic [TimeoutW-1:0] wait_cnt_q;
    logic                m0_err_q;
    logic                m1_err_q;

    assign m0_err_o = m0_err_q;
    assign m1_err_o = m1_err_q;
`else
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            starve_q <= '0;
            grant_q  <= 2'b00;
            s_stb_q  <= 1'b0;
            s_we_q   <= 1'b0;
            s_adr_q  <= '0;
            s_dat_q  <= '0;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            m0_dat_q <= '0;
            m1_dat_q <= '0;
`ifdef TIA_ARB_TIMEOUT_EN
            wait_cnt_q <= '0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (m1_wins) begin
                        state_q  <= StReq;
                        grant_q  <= 2'b10;
                        s_stb_q  <= 1'b1;
                        s_we_q   <= m1_we_i;
                        s_adr_q  <= m1_adr_i;
                        s_dat_q  <= m1_dat_i;
                        starve_q <= '0;
                    end else if (m0_stb_i) begin
                        state_q <= StReq;
                        grant_q <= 2'b01;
                        s_stb_q <= 1'b1;
                        s_we_q  <= m0_we_i;
                        s_adr_q <= m0_adr_i;
                        s_dat_q <= m0_dat_i;
                        if (m1_stb_i && starve_q != StarveMax) begin
                            starve_q <= starve_q + 1'b1;
                        end
                    end
                end
                StReq: begin
                    s_stb_q <= 1'b0;
                    state_q <= StWait;
`ifdef TIA_ARB_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                StWait: begin
                    if (s_ack_i) begin
                        state_q <= StDone;
                        if (grant_q[1]) begin
                            m1_ack_q <= 1'b1;
                            m1_dat_q <= s_dat_i;
                        end else begin
                            m0_ack_q <= 1'b1;
                            m0_dat_q <= s_dat_i;
                        end
                    end
`ifdef TIA_ARB_TIMEOUT_EN
                    else if (wait_cnt_q == TimeoutLast) begin
                        state_q  <= StDone;
                        m1_err_q <= grant_q[1];
                        m0_err_q <= grant_q[0];
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                StDone: begin
                    state_q  <= StIdle;
                    grant_q  <= 2'b00;
                    s_we_q   <= 1'b0;
                    s_adr_q  <= '0;
                    s_dat_q  <= '0;
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    m0_dat_q <= '0;
                    m1_dat_q <= '0;
`ifdef TIA_ARB_TIMEOUT_EN
                    m0_err_q <= 1'b0;
                    m1_err_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign grant_o  = grant_q;
    assign s_stb_o  = s_stb_q;
    assign s_we_o   = s_we_q;
    assign s_adr_o  = s_adr_q;
    assign s_dat_o  = s_dat_q;
    assign m0_ack_o = m0_ack_q;
    assign m1_ack_o = m1_ack_q;
    assign m0_dat_o = m0_dat_q;
    assign m1_dat_o = m1_dat_q;

endmodule

// File: tb/tb_tia_bus_arbiter.sv
// Self-checking bench for tia_bus_arbiter: directed scenarios, then randomized traffic
// against a transaction-level model of the arbitration rules and the E0..E3 timeline.
module tb_tia_bus_arbiter;
    localparam int unsigned SL = 15;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       m0_stb, m0_we, m1_stb, m1_we;
    logic [6:0] m0_adr, m1_adr;
    logic [7:0] m0_dat, m1_dat;
    logic       m0_ack, m0_err, m1_ack, m1_err;
    logic [7:0] m0_rdat, m1_rdat;
    logic       s_stb, s_we, s_ack;
    logic [6:0] s_adr;
    logic [7:0] s_wdat, s_rdat;
    logic       stall;
    logic [1:0] grant;

    tia_bus_arbiter #(
        .WB_ADDR_WIDTH (7),
        .WB_DATA_WIDTH (8),
        .STARVE_LIMIT  (SL),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .m0_stb_i   (m0_stb),
        .m0_we_i    (m0_we),
        .m0_adr_i   (m0_adr),
        .m0_dat_i   (m0_dat),
        .m0_ack_o   (m0_ack),
        .m0_err_o   (m0_err),
        .m0_dat_o   (m0_rdat),
        .m1_stb_i   (m1_stb),
        .m1_we_i    (m1_we),
        .m1_adr_i   (m1_adr),
        .m1_dat_i   (m1_dat),
        .m1_ack_o   (m1_ack),
        .m1_err_o   (m1_err),
        .m1_dat_o   (m1_rdat),
        .s_stb_o    (s_stb),
        .s_we_o     (s_we),
        .s_adr_o    (s_adr),
        .s_dat_o    (s_wdat),
        .s_ack_i    (s_ack),
        .s_dat_i    (s_rdat),
        .stall_cpu_i(stall),
        .grant_o    (grant)
    );

    always #5 clk = ~clk;

    // TIA model: registered port, acks the cycle after the strobe; optional stale or absent acks.
    logic [7:0] rd_table [128];
    logic       stale, no_ack;
    logic       s_ack_q = 1'b0;
    logic [7:0] s_rd_q = 8'h00;
    int         stb_pulses = 0;

    always @(posedge clk) begin
        s_ack_q <= stale | (s_stb & ~no_ack);
        s_rd_q  <= s_stb ? rd_table[s_adr] : 8'($urandom);
        if (s_stb) stb_pulses <= stb_pulses + 1;
    end
    assign s_ack  = s_ack_q;
    assign s_rdat = s_rd_q;

    int tests = 0;
    int fails = 0;
    int starve_m = 0;
    int txns = 0;
    int w;
    logic flip_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic new_req(input int m, input bit force_req);
        logic stb;
        stb = force_req || ($urandom_range(0, 3) != 0);
        if (m == 0) begin
            m0_stb = stb; m0_we = 1'($urandom); m0_adr = 7'($urandom); m0_dat = 8'($urandom);
        end else begin
            m1_stb = stb; m1_we = 1'($urandom); m1_adr = 7'($urandom); m1_dat = 8'($urandom);
        end
    endtask

    // Called at a negedge in IDLE; runs one arbitration and its whole transaction.
    task automatic arbitrate(output int win);
        logic       we;
        logic [6:0] adr;
        logic [7:0] dat, rd;
        if (m1_stb && (!m0_stb || stall || starve_m == SL)) win = 2;
        else if (m0_stb) win = 1;
        else win = 0;
        if (win == 2) starve_m = 0;
        else if (win == 1 && m1_stb && starve_m < SL) starve_m++;
        we  = (win == 2) ? m1_we : m0_we;
        adr = (win == 2) ? m1_adr : m0_adr;
        dat = (win == 2) ? m1_dat : m0_dat;
        rd  = rd_table[adr];
        tick();
        if (win == 0) begin
            chk("idle_grant", grant, 2'b00);
            chk("idle_stb", s_stb, 1'b0);
            return;
        end
        chk("req_grant", grant, (win == 1) ? 2'b01 : 2'b10);
        chk("req_stb", s_stb, 1'b1);
        chk("req_adr", s_adr, adr);
        chk("req_we", s_we, we);
        chk("req_dat", s_wdat, dat);
        chk("req_acks", {m0_ack, m1_ack}, 2'b00);
        if (flip_en && $urandom_range(0, 1) == 1) stall = ~stall;
        tick();
        chk("wait_stb", s_stb, 1'b0);
        chk("wait_acks", {m0_ack, m1_ack}, 2'b00);
        chk("wait_adr", s_adr, adr);
        tick();
        chk("done_acks", {m1_ack, m0_ack}, (win == 1) ? 2'b01 : 2'b10);
        chk("done_win_dat", (win == 1) ? m0_rdat : m1_rdat, rd);
        chk("done_lose_dat", (win == 1) ? m1_rdat : m0_rdat, 8'h00);
        chk("done_errs", {m0_err, m1_err}, 2'b00);
        chk("done_stb", s_stb, 1'b0);
        chk("done_grant", grant, (win == 1) ? 2'b01 : 2'b10);
        tick();
        chk("post_grant", grant, 2'b00);
        chk("post_acks", {m0_ack, m1_ack}, 2'b00);
        chk("post_fields", {s_we, s_adr, s_wdat}, 16'h0000);
        chk("post_dats", {m0_rdat, m1_rdat}, 16'h0000);
        txns++;
    endtask

    initial begin
        stale = 1'b0; no_ack = 1'b0; stall = 1'b0; flip_en = 1'b0;
        m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0;
        m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0;
        for (int i = 0; i < 128; i++) rd_table[i] = 8'($urandom);
        rd_table[7'h0C] = 8'h80;

        repeat (2) tick();
        chk("rst_grant", grant, 2'b00);
        chk("rst_stb", s_stb, 1'b0);
        chk("rst_resp", {m0_ack, m0_err, m1_ack, m1_err}, 4'h0);
        chk("rst_fields", {s_we, s_adr, s_wdat}, 16'h0000);
        rst_ni = 1'b1;
        tick();

        // Master 0 write only
        m0_stb = 1; m0_we = 1; m0_adr = 7'h02; m0_dat = 8'h00;
        arbitrate(w);
        chk("m0_write_win", w, 1);
        m0_stb = 0;

        // Master 1 read only
        m1_stb = 1; m1_we = 0; m1_adr = 7'h0C; m1_dat = 8'h00;
        arbitrate(w);
        chk("m1_read_win", w, 2);
        m1_stb = 0;

        arbitrate(w);
        chk("no_req_win", w, 0);

        // Both requesting continuously: master 1 gets every 16th slot
        new_req(0, 1'b1);
        new_req(1, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            arbitrate(w);
            chk("starve_pattern", w, (k % 16 == 0) ? 2 : 1);
            new_req((w == 2) ? 1 : 0, 1'b1);
        end

        // WSYNC stall hands the bus to master 1
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            arbitrate(w);
            chk("stall_win", w, 2);
            new_req(1, 1'b1);
        end
        stall = 1'b0;
        arbitrate(w);
        chk("unstall_win", w, 1);

        // Stale acks held high, plus randomized traffic with mid-transaction stall changes
        stale = 1'b1;
        for (int k = 0; k < 6; k++) begin
            arbitrate(w);
            if (w == 1 || !m0_stb) new_req(0, 1'b0);
            if (w == 2 || !m1_stb) new_req(1, 1'b0);
        end
        flip_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            stale = 1'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            arbitrate(w);
            if (w == 1 || !m0_stb) new_req(0, 1'b0);
            if (w == 2 || !m1_stb) new_req(1, 1'b0);
        end
        flip_en = 1'b0;
        stale = 1'b0;
        chk("stb_pulse_count", stb_pulses, txns);

        // Silent TIA: timeout (if built in) and asynchronous reset mid-WAIT
        no_ack = 1'b1;
        stall = 1'b0;
        m1_stb = 0;
        m0_stb = 1; m0_we = 0; m0_adr = 7'h05; m0_dat = 8'h00;
        tick();
        chk("silent_req_grant", grant, 2'b01);
`ifdef TIA_ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("to_pending", {m0_ack, m0_err}, 2'b00);
        end
        tick();
        chk("to_err", m0_err, 1'b1);
        chk("to_ack", m0_ack, 1'b0);
        chk("to_dat", m0_rdat, 8'h00);
        chk("to_m1", {m1_ack, m1_err}, 2'b00);
        tick();
        chk("to_after", {m0_err, grant}, 3'b000);
        m0_stb = 0;
        m1_stb = 1; m1_we = 1; m1_adr = 7'h2B; m1_dat = 8'h5A;
        starve_m = 0;
        repeat (3) tick();
        chk("rst_pre_grant", grant, 2'b10);
`else
        repeat (12) tick();
        chk("wait_persists", {m0_ack, m0_err, grant}, 4'b0001);
`endif
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_grant", grant, 2'b00);
        chk("async_rst_stb", s_stb, 1'b0);
        chk("async_rst_resp", {m0_ack, m0_err, m1_ack, m1_err}, 4'h0);
        chk("async_rst_fields", {s_we, s_adr, s_wdat, m0_rdat, m1_rdat}, 32'h0);
        no_ack = 1'b0;
        m0_stb = 0; m1_stb = 0;
        starve_m = 0;
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        m0_stb = 1; m0_we = 1; m0_adr = 7'h2A; m0_dat = 8'h11;
        arbitrate(w);
        chk("post_rst_win", w, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
